// File: rtl/cache_controller_if.sv
// ----------------------------------------------------------------------------
// cache_controller_if
// Bundles the MEM-stage request/response signals and the SRAM controller
// request/ready signals used by cache_controller.
//   mem_rd_en / mem_wr_en : MEM-stage load / store request
//   address / write_data  : byte address and store data (held while ready=0)
//   read_data / ready     : load data and pipeline-freeze (0 = stall)
//   sram_rd_en/sram_wr_en : read / write request to the SRAM controller
//   sram_address/_wdata   : pass-through address and store data
//   sram_rdata/sram_ready : SRAM read data and controller ready
// Modports:
//   slave  - the cache controller
//   master - the environment (pipeline + SRAM controller side)
// ----------------------------------------------------------------------------
interface cache_controller_if;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    modport slave (
        input  mem_rd_en, mem_wr_en, address, write_data, sram_rdata, sram_ready,
        output read_data, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
    );

    modport master (
        output mem_rd_en, mem_wr_en, address, write_data, sram_rdata, sram_ready,
        input  read_data, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
    );
endinterface

// File: rtl/cache_controller.sv
// ----------------------------------------------------------------------------
// cache_controller
// 2-way set-associative, write-through, no-write-allocate read cache placed
// between the MEM stage and the SRAM controller. Read hits complete in the
// same cycle; read misses fetch one word from SRAM and fill the victim way;
// every store is forwarded to SRAM (and updates the cached copy on a hit).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - cache_controller_if.slave (MEM-stage and SRAM controller signals)
// ----------------------------------------------------------------------------
module cache_controller #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 11
) (
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus
);
    localparam int SETS = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MISS_RD = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t                state_r;
    logic                  acked_r;
    logic [SETS-1:0]       valid0_r;
    logic [SETS-1:0]       valid1_r;
    logic [SETS-1:0]       lru_r;
    logic [TAG_BITS-1:0]   tag0_r  [SETS];
    logic [TAG_BITS-1:0]   tag1_r  [SETS];
    logic [31:0]           data0_r [SETS];
    logic [31:0]           data1_r [SETS];

    logic [INDEX_BITS-1:0] idx_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic                  hit0_s;
    logic                  hit1_s;
    logic                  hit_s;
    logic                  victim_s;
    logic                  done_s;
    logic                  ready_s;
    logic [31:0]           read_data_s;
    logic                  addr_unused_s;

    assign idx_s  = bus.address[INDEX_BITS+1:2];
    assign tag_s  = bus.address[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign addr_unused_s = ^{bus.address[31:INDEX_BITS+TAG_BITS+2], bus.address[1:0]};

    assign hit0_s = valid0_r[idx_s] && (tag0_r[idx_s] == tag_s);
    assign hit1_s = valid1_r[idx_s] && (tag1_r[idx_s] == tag_s);
    assign hit_s  = hit0_s || hit1_s;

    // Prefer an empty way (way 0 first) before evicting the LRU way.
    assign victim_s = !valid0_r[idx_s] ? 1'b0 :
                      !valid1_r[idx_s] ? 1'b1 : lru_r[idx_s];

    // sram_ready is high while the controller is idle, so completion is only
    // recognised after it has dropped once (request accepted) and risen again.
    assign done_s = acked_r && bus.sram_ready;

    // Enables come straight from the registered state.
    assign bus.sram_rd_en   = (state_r == MISS_RD);
    assign bus.sram_wr_en   = (state_r == WRITE);
    assign bus.sram_address = bus.address;
    assign bus.sram_wdata   = bus.write_data;
    assign bus.ready        = ready_s;
    assign bus.read_data    = read_data_s;

    // Pipeline handshake and load data: hit data or forwarded SRAM data.
    always_comb begin
        ready_s     = 1'b1;
        read_data_s = 32'd0;
        if (!rst) begin
            ready_s     = 1'b1;
            read_data_s = 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.mem_wr_en) begin
                        ready_s = 1'b0;
                    end else if (bus.mem_rd_en) begin
                        if (hit_s) begin
                            ready_s     = 1'b1;
                            read_data_s = hit1_s ? data1_r[idx_s] : data0_r[idx_s];
                        end else begin
                            ready_s = 1'b0;
                        end
                    end else begin
                        ready_s = 1'b1;
                    end
                end
                MISS_RD: begin
                    if (done_s) begin
                        ready_s     = 1'b1;
                        read_data_s = bus.sram_rdata;
                    end else begin
                        ready_s = 1'b0;
                    end
                end
                WRITE: begin
                    ready_s = done_s;
                end
                default: begin
                    ready_s = 1'b1;
                end
            endcase
        end
    end

    // Control FSM with valid and LRU bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            acked_r  <= 1'b0;
            valid0_r <= {SETS{1'b0}};
            valid1_r <= {SETS{1'b0}};
            lru_r    <= {SETS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    acked_r <= 1'b0;
                    if (bus.mem_wr_en) begin
                        state_r <= WRITE;
                        if (hit_s) begin
                            lru_r[idx_s] <= ~hit1_s;
                        end
                    end else if (bus.mem_rd_en) begin
                        if (hit_s) begin
                            lru_r[idx_s] <= ~hit1_s;
                        end else begin
                            state_r <= MISS_RD;
                        end
                    end
                end
                MISS_RD: begin
                    if (done_s) begin
                        state_r <= IDLE;
                        acked_r <= 1'b0;
                        lru_r[idx_s] <= ~victim_s;
                        if (victim_s) begin
                            valid1_r[idx_s] <= 1'b1;
                        end else begin
                            valid0_r[idx_s] <= 1'b1;
                        end
                    end else if (!bus.sram_ready) begin
                        acked_r <= 1'b1;
                    end
                end
                WRITE: begin
                    if (done_s) begin
                        state_r <= IDLE;
                        acked_r <= 1'b0;
                    end else if (!bus.sram_ready) begin
                        acked_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    acked_r <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays (not reset; qualified by valid). While reset is held
    // the state is IDLE and nothing is valid, so no write can occur.
    always_ff @(posedge clk) begin
        if ((state_r == IDLE) && bus.mem_wr_en && hit_s) begin
            if (hit1_s) begin
                data1_r[idx_s] <= bus.write_data;
            end else begin
                data0_r[idx_s] <= bus.write_data;
            end
        end else if ((state_r == MISS_RD) && done_s) begin
            if (victim_s) begin
                tag1_r[idx_s]  <= tag_s;
                data1_r[idx_s] <= bus.sram_rdata;
            end else begin
                tag0_r[idx_s]  <= tag_s;
                data0_r[idx_s] <= bus.sram_rdata;
            end
        end
    end
endmodule
